// File: rtl/gray_code_counter.sv
// gray_code_counter
//   WIDTH-bit up/down counter. It presents the count in both binary (b) and
//   Gray (g) every cycle. It can load a start value given in binary or Gray,
//   and it flags boundary crossings on term.
//
//   Parameters:
//     WIDTH  counter/code width, 2..32
//     WRAP   1 = wrap at the boundaries, 0 = saturate at the boundaries
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     en           count enable (one step per cycle)
//     up_dn        direction, 1 = up, 0 = down (only used when counting)
//     load         synchronous load strobe (has priority over en)
//     load_is_gray load_val is Gray-coded when 1, binary when 0
//     load_val     load value
//     b            registered binary count
//     g            registered Gray count, always b ^ (b >> 1)
//     out_valid    count has been defined by a load or a count step
//     term         one-cycle pulse on a wrap, or on first entry to a saturated hold
//     err          sticky Gray-sequence error flag
//
//   Build option:
//     GRAY_CHECK_EN  when defined, a checker flags any count step whose Gray
//                    code changes by other than exactly one bit. When it is
//                    not defined, err is tied to 0.
module gray_code_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             out_valid,
    output logic             term,
    output logic             err
);

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             vld_q, vld_d;
    logic             term_q, term_d;
    // Set while the counter sits in a saturated hold. It makes term fire only
    // on the first blocked step, not on every one after that.
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] ld_bin;
    logic             at_max, at_min;

    assign at_max = &b_q;
    assign at_min = ~|b_q;

    always_comb begin
        // Gray-to-binary conversion: prefix XOR running from the MSB down.
        ld_bin = load_val;
        if (load_is_gray) begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                ld_bin[i] = ld_bin[i+1] ^ load_val[i];
            end
        end
    end

    always_comb begin
        b_d    = b_q;
        vld_d  = vld_q;
        term_d = 1'b0;
        sat_d  = sat_q;
        if (load) begin
            b_d   = ld_bin;
            vld_d = 1'b1;
            sat_d = 1'b0;
        end else if (en) begin
            vld_d = 1'b1;
            if ((up_dn && at_max) || (!up_dn && at_min)) begin
                if (WRAP) begin
                    b_d    = up_dn ? '0 : '1;
                    term_d = 1'b1;
                end else begin
                    term_d = ~sat_q;
                    sat_d  = 1'b1;
                end
            end else begin
                b_d   = up_dn ? b_q + WIDTH'(1) : b_q - WIDTH'(1);
                sat_d = 1'b0;
            end
        end
        // Gray is derived from the same next value, so b and g never skew.
        g_d = b_d ^ (b_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= '0;
            g_q    <= '0;
            vld_q  <= 1'b0;
            term_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            b_q    <= b_d;
            g_q    <= g_d;
            vld_q  <= vld_d;
            term_q <= term_d;
            sat_q  <= sat_d;
        end
    end

`ifdef GRAY_CHECK_EN
    // chk_q marks a cycle that follows a real count step, meaning b changed.
    // Loads and saturated holds never set it, so those cycles are exempt.
    logic [WIDTH-1:0] gprev_q;
    logic [WIDTH-1:0] gdiff;
    logic             chk_q, chk_d;
    logic             err_q, err_d;

    assign chk_d = en & ~load & (b_d != b_q);
    assign gdiff = g_q ^ gprev_q;

    always_comb begin
        err_d = err_q;
        // The change is legal only when exactly one bit differs: non-zero
        // and a power of two.
        if (chk_q && ((gdiff == '0) || ((gdiff & (gdiff - WIDTH'(1))) != '0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gprev_q <= '0;
            chk_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            gprev_q <= g_q;
            chk_q   <= chk_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign b         = b_q;
    assign g         = g_q;
    assign out_valid = vld_q;
    assign term      = term_q;

endmodule

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
- Parametrised, registered successor to the fixed 4-bit binary-to-Gray converter.
- WIDTH-bit up/down counter that presents its count in binary and Gray every cycle.
- Loads a start value given in either binary or Gray, and flags boundary crossings.
- Used as the pointer/sequence source for clock-domain-crossing logic and as a self-checking Gray stimulus generator.

Parameters:
- WIDTH, 4, counter/code width in bits; legal range 2..32.
- WRAP, 1, boundary mode: 1 = wrap around (max->0 up, 0->max down); 0 = saturate at boundary.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; advance one step per cycle while high.
- up_dn  input  1  direction: 1 = up, 0 = down; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_is_gray  input  1  1 = load_val is Gray-coded; 0 = load_val is binary.
- load_val  input  WIDTH  load value.
- b  output  WIDTH  registered binary count.
- g  output  WIDTH  registered Gray count; always equals b ^ (b >> 1) in the same cycle.
- out_valid  output  1  high once the count has been defined by a load or a count step.
- term  output  1  one-cycle pulse when a boundary is crossed (wrap) or reached (saturate).
- err  output  1  sticky Gray-sequence error flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - b=0, g=0, out_valid=0, term=0, err=0.
  - Release is synchronous to the next clk edge. The first edge after release does not count unless en=1.
- All outputs are registered. Latency is one clk edge from the sampled control inputs to the new b/g.
- b_next and g_next are computed together from the same next value, so b and g are never skewed.
- Priority each cycle: load > en > hold.
- Load:
  - load_is_gray=0: b_next = load_val.
  - load_is_gray=1: b_next[WIDTH-1] = load_val[WIDTH-1]; b_next[i] = b_next[i+1] ^ load_val[i], for i from WIDTH-2 down to 0.
  - Load sets out_valid=1 and never asserts term.
- Count (en=1, load=0):
  - up: b+1; down: b-1; arithmetic is modulo 2^WIDTH.
  - WRAP=1, up from all-ones: b_next=0, term=1 for one cycle.
  - WRAP=1, down from 0: b_next = all-ones, term=1 for one cycle.
  - WRAP=0, up at all-ones or down at 0: b holds. term=1 on the cycle the hold is first entered, then 0 while held at the boundary.
  - WRAP=0: stepping away from the boundary in the opposite direction is normal counting.
  - Any count step sets out_valid=1.
- Hold (en=0, load=0): b, g, out_valid unchanged; term=0.
- Simultaneous load and en: load wins; direction is ignored that cycle.
- Reset mid-count: all state is lost immediately; term never fires as a result of reset.
- up_dn may change on any cycle; it is sampled only when en=1 and load=0.

Optional Feature:
- Macro: GRAY_CHECK_EN.
- Defined:
  - A checker registers the previous g.
  - On every cycle that follows a count step where b actually changed, popcount(g ^ g_prev) must be exactly 1. Otherwise err is set and remains 1 until reset.
  - Load cycles and saturated-hold cycles are exempt.
- Not defined: the checker logic is absent and err is tied to 0.
- The port list is identical in both builds.

Test Plan:
- Reset: WIDTH=4, rst_n=0 asserted mid-cycle -> b=0, g=0, out_valid=0, term=0 with no clk edge; release, en=0 for 3 cycles -> b stays 0, out_valid=0.
- Count up 17 steps, WIDTH=4, WRAP=1 -> g follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,...,1000,0000; b=15->0 with term=1 for exactly one cycle; g==b^(b>>1) checked every cycle.
- Gray load: load=1, load_is_gray=1, load_val=4'b1000 -> b=4'b1111, g=4'b1000, out_valid=1, term=0; then en=1, up_dn=1 -> b=0, g=0, term=1.
- Down wrap and simultaneous events: load binary 0; en=1, up_dn=0 -> b=15, g=1000, term=1; then load=1 with en=1 and load_val=5 (binary) -> b=5, g=0111, no count step.
- Saturate: WRAP=0, load 14, en=1, up_dn=1 for 4 cycles -> b=15 then holds at 15; term pulses once; then up_dn=0 -> b=14.
- GRAY_CHECK_EN defined: 40-cycle random en/up_dn/load mix -> err stays 0; force a g bit-flip via bench override -> err=1 and stays 1 until rst_n=0.
